knapsack_seq_checker: RTL and testbench

//   Parametrised, sequential successor to the fixed 3-item feasibility checker.
//   Per-item value/weight/volume coefficients and the three limits are runtime-loaded.

---
 rtl/knapsack_seq_checker.sv | 185 ++++++++++++++++++
 tb/tb_knapsack_seq_checker.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knapsack_seq_checker.sv
// Sequential knapsack feasibility checker: runtime-loaded coefficient tables, one item per cycle.
// Optional KNAP_OVERFLOW_CHK_EN adds out_overflow with saturating totals.
module knapsack_seq_checker #(
    parameter int N_ITEMS = 3,
    parameter int W       = 6,
    parameter int IDX_W   = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_sel,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [W-1:0]       cfg_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_ITEMS-1:0] in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_feasible,
    output logic [W-1:0]       out_value,
    output logic [W-1:0]       out_weight,
    output logic [W-1:0]       out_volume,
`ifdef KNAP_OVERFLOW_CHK_EN
    output logic               out_overflow,
`endif
    output logic               busy
);

`ifdef KNAP_OVERFLOW_CHK_EN
    localparam int SW = W + 1;
`else
    localparam int SW = W;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nxt;

    logic [W-1:0]       val_tbl [N_ITEMS];
    logic [W-1:0]       wgt_tbl [N_ITEMS];
    logic [W-1:0]       vol_tbl [N_ITEMS];
    logic [W-1:0]       min_value, max_weight, max_volume;
    logic [N_ITEMS-1:0] sel;
    logic [IDX_W-1:0]   idx;
    logic [W-1:0]       acc_val, acc_wgt, acc_vol;
    logic [W-1:0]       val_n, wgt_n, vol_n;
    logic [W-1:0]       add_val, add_wgt, add_vol;
    logic [SW-1:0]      s_val, s_wgt, s_vol;
    logic               accept, last, feas_n, cfg_ok;

`ifdef KNAP_OVERFLOW_CHK_EN
    logic ov_val, ov_wgt, ov_vol;
    logic ov_val_n, ov_wgt_n, ov_vol_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        cfg_ok    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                cfg_ok   = cfg_we;
                accept   = in_valid;
                if (in_valid) state_nxt = ACCUM;
            end
            ACCUM: if (last) state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == DONE);
    assign last      = (idx == IDX_W'(N_ITEMS - 1));

    always_comb begin
        add_val = sel[idx] ? val_tbl[idx] : '0;
        add_wgt = sel[idx] ? wgt_tbl[idx] : '0;
        add_vol = sel[idx] ? vol_tbl[idx] : '0;
        s_val   = SW'(acc_val) + SW'(add_val);
        s_wgt   = SW'(acc_wgt) + SW'(add_wgt);
        s_vol   = SW'(acc_vol) + SW'(add_vol);
`ifdef KNAP_OVERFLOW_CHK_EN
        // A total that ever carried out stays pinned at all-ones
        ov_val_n = ov_val | s_val[W];
        ov_wgt_n = ov_wgt | s_wgt[W];
        ov_vol_n = ov_vol | s_vol[W];
        val_n    = ov_val_n ? {W{1'b1}} : s_val[W-1:0];
        wgt_n    = ov_wgt_n ? {W{1'b1}} : s_wgt[W-1:0];
        vol_n    = ov_vol_n ? {W{1'b1}} : s_vol[W-1:0];
        feas_n   = (val_n >= min_value) && (wgt_n <= max_weight) &&
                   (vol_n <= max_volume) &&
                   !(ov_val_n || ov_wgt_n || ov_vol_n);
`else
        val_n    = s_val;
        wgt_n    = s_wgt;
        vol_n    = s_vol;
        feas_n   = (val_n >= min_value) && (wgt_n <= max_weight) &&
                   (vol_n <= max_volume);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                val_tbl[i] <= '0;
                wgt_tbl[i] <= '0;
                vol_tbl[i] <= '0;
            end
            min_value    <= '0;
            max_weight   <= '0;
            max_volume   <= '0;
        end else if (cfg_ok) begin
            unique case (cfg_sel)
                2'd0: if (int'(cfg_idx) < N_ITEMS) val_tbl[cfg_idx] <= cfg_data;
                2'd1: if (int'(cfg_idx) < N_ITEMS) wgt_tbl[cfg_idx] <= cfg_data;
                2'd2: if (int'(cfg_idx) < N_ITEMS) vol_tbl[cfg_idx] <= cfg_data;
                default: begin
                    if (int'(cfg_idx) == 0)      min_value  <= cfg_data;
                    else if (int'(cfg_idx) == 1) max_weight <= cfg_data;
                    else if (int'(cfg_idx) == 2) max_volume <= cfg_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel          <= '0;
            idx          <= '0;
            acc_val      <= '0;
            acc_wgt      <= '0;
            acc_vol      <= '0;
            out_value    <= '0;
            out_weight   <= '0;
            out_volume   <= '0;
            out_feasible <= 1'b0;
`ifdef KNAP_OVERFLOW_CHK_EN
            ov_val       <= 1'b0;
            ov_wgt       <= 1'b0;
            ov_vol       <= 1'b0;
            out_overflow <= 1'b0;
`endif
        end else if (accept) begin
            sel     <= in_sel;
            idx     <= '0;
            acc_val <= '0;
            acc_wgt <= '0;
            acc_vol <= '0;
`ifdef KNAP_OVERFLOW_CHK_EN
            ov_val  <= 1'b0;
            ov_wgt  <= 1'b0;
            ov_vol  <= 1'b0;
`endif
        end else if (state == ACCUM) begin
            acc_val <= val_n;
            acc_wgt <= wgt_n;
            acc_vol <= vol_n;
            idx     <= last ? '0 : idx + IDX_W'(1);
`ifdef KNAP_OVERFLOW_CHK_EN
            ov_val  <= ov_val_n;
            ov_wgt  <= ov_wgt_n;
            ov_vol  <= ov_vol_n;
`endif
            if (last) begin
                out_value    <= val_n;
                out_weight   <= wgt_n;
                out_volume   <= vol_n;
                out_feasible <= feas_n;
`ifdef KNAP_OVERFLOW_CHK_EN
                out_overflow <= ov_val_n | ov_wgt_n | ov_vol_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_knapsack_seq_checker.sv
// Randomized bench for knapsack_seq_checker against a plain-arithmetic model.
// Honours KNAP_OVERFLOW_CHK_EN the same way as the design.
module tb_knapsack_seq_checker;

    typedef struct {
        int v;
        int w;
        int o;
        int f;
        int ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [1:0] cfg_idx;
    logic [5:0] cfg_data;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_sel;
    logic       out_valid;
    logic       out_ready;
    logic       out_feasible;
    logic [5:0] out_value, out_weight, out_volume;
    logic       busy;
`ifdef KNAP_OVERFLOW_CHK_EN
    logic       out_overflow;
`endif

    int checks = 0;
    int errors = 0;

    int mv[3], mw[3], mo[3];
    int lmin, lw, lv;
    exp_t exp_q[$];
    int r_v, r_w, r_o, r_f, r_ov, lat;

    knapsack_seq_checker dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
        .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_feasible(out_feasible), .out_value(out_value),
        .out_weight(out_weight), .out_volume(out_volume),
`ifdef KNAP_OVERFLOW_CHK_EN
        .out_overflow(out_overflow),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            mv[i] = 0; mw[i] = 0; mo[i] = 0;
        end
        lmin = 0; lw = 0; lv = 0;
    endfunction

    function automatic void model_write(input int s, input int i, input int d);
        if (i > 2) return;
        case (s)
            0: mv[i] = d;
            1: mw[i] = d;
            2: mo[i] = d;
            default: begin
                if (i == 0) lmin = d;
                else if (i == 1) lw = d;
                else lv = d;
            end
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] s);
        exp_t e;
        int sv = 0, sw = 0, so = 0;
        for (int i = 0; i < 3; i++)
            if (s[i]) begin
                sv += mv[i]; sw += mw[i]; so += mo[i];
            end
`ifdef KNAP_OVERFLOW_CHK_EN
        e.ov = (sv > 63 || sw > 63 || so > 63) ? 1 : 0;
        e.v  = (sv > 63) ? 63 : sv;
        e.w  = (sw > 63) ? 63 : sw;
        e.o  = (so > 63) ? 63 : so;
`else
        e.ov = 0;
        e.v  = sv % 64;
        e.w  = sw % 64;
        e.o  = so % 64;
`endif
        e.f = (e.v >= lmin && e.w <= lw && e.o <= lv && e.ov == 0) ? 1 : 0;
        return e;
    endfunction

    // Every cycle a result is presented it must equal the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("value", int'(out_value), e.v);
                    chk("weight", int'(out_weight), e.w);
                    chk("volume", int'(out_volume), e.o);
                    chk("feasible", int'(out_feasible), e.f);
`ifdef KNAP_OVERFLOW_CHK_EN
                    chk("overflow", int'(out_overflow), e.ov);
`endif
                end
            end
        end
    end

    always @(posedge clk)
        if (rst_n && out_valid && out_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());

    task automatic cfg_write(input int s, input int i, input int d);
        cfg_we   = 1'b1;
        cfg_sel  = 2'(s);
        cfg_idx  = 2'(i);
        cfg_data = 6'(d);
        model_write(s, i, d);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic cand(input logic [2:0] s, input int hold,
                        input bit w, input int ws, input int wi, input int wd);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 40) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        if (w) begin
            cfg_we = 1'b1; cfg_sel = 2'(ws); cfg_idx = 2'(wi); cfg_data = 6'(wd);
            model_write(ws, wi, wd);
        end
        in_valid = 1'b1;
        in_sel   = s;
        exp_q.push_back(model(s));
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        in_sel   = 3'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        if (lat >= 40) begin
            chk("out_valid_timeout", 0, 1);
            return;
        end
        chk("latency", lat, 4);
        r_v = int'(out_value); r_w = int'(out_weight);
        r_o = int'(out_volume); r_f = int'(out_feasible);
`ifdef KNAP_OVERFLOW_CHK_EN
        r_ov = int'(out_overflow);
`else
        r_ov = 0;
`endif
        #1;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_sel   = 3'($urandom);
            cfg_we   = 1'b1;
            cfg_sel  = 2'($urandom);
            cfg_idx  = 2'($urandom);
            cfg_data = 6'($urandom);
            @(negedge clk);
            chk("in_ready_held_low", int'(in_ready), 0);
            chk("out_valid_held", int'(out_valid), 1);
            #1;
        end
        in_valid  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_idx = '0; cfg_data = '0;
        in_valid = 1'b0; in_sel = '0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_value", int'(out_value), 0);
        chk("rst_weight", int'(out_weight), 0);
        chk("rst_volume", int'(out_volume), 0);
        chk("rst_feasible", int'(out_feasible), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        cfg_write(0, 0, 4); cfg_write(0, 1, 2); cfg_write(0, 2, 2);
        cfg_write(1, 0, 12); cfg_write(1, 1, 1); cfg_write(1, 2, 20);
        cfg_write(2, 0, 1); cfg_write(2, 1, 1); cfg_write(2, 2, 1);
        cfg_write(3, 0, 6); cfg_write(3, 1, 15); cfg_write(3, 2, 5);

        cand(3'b011, 0, 0, 0, 0, 0);
        chk("lit011_value", r_v, 6);
        chk("lit011_weight", r_w, 13);
        chk("lit011_volume", r_o, 2);
        chk("lit011_feasible", r_f, 1);
        cand(3'b101, 5, 0, 0, 0, 0);
        chk("lit101_value", r_v, 6);
        chk("lit101_weight", r_w, 32);
        chk("lit101_feasible", r_f, 0);
        cand(3'b001, 0, 0, 0, 0, 0);
        chk("lit001_value", r_v, 4);
        chk("lit001_feasible", r_f, 0);
        cand(3'b000, 0, 0, 0, 0, 0);
        chk("lit000_value", r_v, 0);
        chk("lit000_feasible", r_f, 0);

        cfg_write(1, 0, 40); cfg_write(1, 1, 30); cfg_write(1, 2, 0);
        cfg_write(1, 3, 5);
        cand(3'b011, 2, 0, 0, 0, 0);
`ifdef KNAP_OVERFLOW_CHK_EN
        chk("ovf_weight", r_w, 63);
        chk("ovf_flag", r_ov, 1);
        chk("ovf_feasible", r_f, 0);
`else
        chk("wrap_weight", r_w, 6);
        chk("wrap_overflow_none", r_ov, 0);
        chk("wrap_feasible", r_f, 1);
`endif

        cand(3'b100, 0, 1, 0, 2, 9);
        chk("samecycle_write_value", r_v, 9);

        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                cfg_write($urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 63));
            cand(3'($urandom), $urandom_range(0, 3), 1'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 63));
        end

        in_valid = 1'b1;
        in_sel   = 3'b111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_clear();
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cand(3'b111, 0, 0, 0, 0, 0);
        chk("postrst_value", r_v, 0);
        chk("postrst_weight", r_w, 0);
        chk("postrst_volume", r_o, 0);
        chk("postrst_feasible", r_f, 1);

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
